// File: rtl/dac081s101.sv
// Serial driver for the TI DAC081S101: one 16-bit SYNC-framed word per
// four-phase writeReq/writeComplete handshake, with an enforced quiet gap.
module dac081s101 #(
    parameter int         DAC_RES          = 8,
    parameter int         FRAME_BITS       = 16,
    parameter logic [2:0] TICKS_WAIT_QUIET = 3'd4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               writeReq,
    input  logic [DAC_RES-1:0] datain,
    input  logic [1:0]         pdMode,
    output logic               sync,
    output logic               mosi,
    output logic               writeComplete
);

    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam int PAD_W = FRAME_BITS - DAC_RES - 4;

    typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

    state_t                stateReg, stateNext;
    logic [FRAME_BITS-1:0] shiftReg, shiftNext;
    logic [CNT_W-1:0]      bitCnt, bitCntNext;
    logic [2:0]            quietReg, quietNext;
    logic                  syncNext, mosiNext, ackNext;
    logic [FRAME_BITS-1:0] frameWord;

    // Two leading don't-care zeros, PD1:PD0, the sample, then trailing zeros.
    assign frameWord = {2'b00, pdMode, datain, {PAD_W{1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg      <= (TICKS_WAIT_QUIET == 3'd0) ? IDLE : QUIET;
            shiftReg      <= '0;
            bitCnt        <= '0;
            quietReg      <= TICKS_WAIT_QUIET;
            sync          <= 1'b1;
            mosi          <= 1'b0;
            writeComplete <= 1'b1;
        end else begin
            stateReg      <= stateNext;
            shiftReg      <= shiftNext;
            bitCnt        <= bitCntNext;
            quietReg      <= quietNext;
            sync          <= syncNext;
            mosi          <= mosiNext;
            writeComplete <= ackNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        shiftNext  = shiftReg;
        bitCntNext = bitCnt;
        quietNext  = quietReg;
        syncNext   = sync;
        mosiNext   = mosi;
        ackNext    = writeComplete;

        // Ack release runs independently of the quiet countdown.
        if (!writeComplete && writeReq) begin
            ackNext = 1'b1;
        end

        case (stateReg)
            IDLE: begin
                if (!writeReq && writeComplete) begin
                    stateNext  = SHIFT;
                    shiftNext  = frameWord;
                    syncNext   = 1'b0;
                    mosiNext   = frameWord[FRAME_BITS-1];
                    bitCntNext = CNT_W'(FRAME_BITS - 1);
                end
            end
            SHIFT: begin
                if (bitCnt != '0) begin
                    shiftNext  = shiftReg << 1;
                    mosiNext   = shiftReg[FRAME_BITS-2];
                    bitCntNext = bitCnt - CNT_W'(1);
                end else begin
                    // Frame end: ack only a request that is still being held.
                    syncNext  = 1'b1;
                    mosiNext  = 1'b0;
                    quietNext = TICKS_WAIT_QUIET;
                    ackNext   = writeReq;
                    stateNext = (TICKS_WAIT_QUIET == 3'd0) ? IDLE : QUIET;
                end
            end
            QUIET: begin
                if (quietReg != 3'd0) begin
                    quietNext = quietReg - 3'd1;
                end
                if (quietReg <= 3'd1) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                syncNext  = 1'b1;
                mosiNext  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dac081s101.sv
// Randomised self-checking bench for dac081s101; a negedge monitor captures
// each SYNC-low frame and the scenario tasks compare it with the frame rule.
module tb_dac081s101;

    localparam int TICKS = 4;

    logic       clk;
    logic       reset;
    logic       writeReq;
    logic [7:0] datain;
    logic [1:0] pdMode;
    logic       sync;
    logic       mosi;
    logic       writeComplete;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] bits;
        int          len;
        logic        ack;
        int          gap;
    } frame_t;

    frame_t fq[$];

    dac081s101 dut (
        .clk(clk),
        .reset(reset),
        .writeReq(writeReq),
        .datain(datain),
        .pdMode(pdMode),
        .sync(sync),
        .mosi(mosi),
        .writeComplete(writeComplete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: collect bits while sync is low, log frame length, the ack seen
    // on the first high cycle, and how many high cycles preceded the frame.
    logic [15:0] curBits = '0;
    int          curLen = 0;
    int          curGap = 0;
    int          gapCnt = 1000;
    bit          inFrame = 0;
    int          idleMosiBad = 0;

    always @(negedge clk) begin
        if (sync === 1'b0) begin
            if (!inFrame) begin
                inFrame = 1;
                curBits = '0;
                curLen  = 0;
                curGap  = gapCnt;
            end
            curBits = {curBits[14:0], mosi};
            curLen++;
        end else begin
            if (inFrame) begin
                fq.push_back('{bits: curBits, len: curLen, ack: writeComplete, gap: curGap});
                inFrame = 0;
                gapCnt  = 0;
            end
            gapCnt++;
            if (mosi !== 1'b0) idleMosiBad++;
        end
    end

    function automatic logic [15:0] expFrame(input logic [7:0] d, input logic [1:0] pd);
        return 16'((int'(pd) << 12) + (int'(d) << 4));
    endfunction

    task automatic waitAck(input logic v, input int lim, output bit ok);
        int n = 0;
        while (writeComplete !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        ok = (writeComplete === v);
    endtask

    task automatic waitSyncLow(input int lim, output bit ok);
        int n = 0;
        while (sync !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        ok = (sync === 1'b0);
    endtask

    task automatic request(input logic [7:0] d, input logic [1:0] pd, output bit ok);
        bit a, b;
        @(negedge clk);
        datain   = d;
        pdMode   = pd;
        writeReq = 1'b0;
        waitAck(1'b0, 100, a);
        writeReq = 1'b1;
        datain   = 8'($urandom);
        pdMode   = 2'($urandom);
        waitAck(1'b1, 10, b);
        ok = a & b;
    endtask

    task automatic popFrame(output frame_t f, output bit ok);
        int n = 0;
        while (fq.size() == 0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        ok = (fq.size() > 0);
        if (ok) f = fq.pop_front();
        else    f = '{bits: '0, len: 0, ack: 1'b1, gap: 0};
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        writeReq = 1'b1;
        datain   = '0;
        pdMode   = '0;
        repeat (3) @(negedge clk);
        checks++; if (sync !== 1'b1) begin errors++; $display("FAIL reset_sync got=%b want=1", sync); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b want=0", mosi); end
        checks++; if (writeComplete !== 1'b1) begin errors++; $display("FAIL reset_ack got=%b want=1", writeComplete); end
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic;
        bit ok;
        frame_t f;
        repeat (6) @(negedge clk);
        datain   = 8'hA5;
        pdMode   = 2'b00;
        writeReq = 1'b0;
        waitAck(1'b0, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_ack_timeout got=%b want=0", writeComplete); end
        writeReq = 1'b1;
        @(negedge clk);
        checks++; if (writeComplete !== 1'b1) begin errors++; $display("FAIL basic_ack_release got=%b want=1", writeComplete); end
        popFrame(f, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_no_frame got=none want=frame"); end
        checks++; if (f.bits !== 16'h0A50) begin errors++; $display("FAIL basic_bits got=%h want=0a50", f.bits); end
        checks++; if (f.len != 16) begin errors++; $display("FAIL basic_len got=%0d want=16", f.len); end
        checks++; if (f.ack !== 1'b0) begin errors++; $display("FAIL basic_ack_at_end got=%b want=0", f.ack); end
        $display("basic frame d=a5 pd=0 bits=%h len=%0d", f.bits, f.len);
    endtask

    task automatic test_pd;
        bit ok, ok2;
        frame_t f;
        request(8'hFF, 2'b11, ok);
        popFrame(f, ok2);
        checks++; if (!(ok && ok2)) begin errors++; $display("FAIL pd_timeout got=%b%b want=11", ok, ok2); end
        checks++; if (f.bits !== 16'h3FF0) begin errors++; $display("FAIL pd_bits got=%h want=3ff0", f.bits); end
        checks++; if (f.len != 16) begin errors++; $display("FAIL pd_len got=%0d want=16", f.len); end
        $display("pd frame d=ff pd=3 bits=%h", f.bits);
    endtask

    task automatic test_random;
        bit ok, ok2;
        frame_t f;
        logic [7:0] d;
        logic [1:0] pd;
        for (int i = 0; i < 10; i++) begin
            d  = 8'($urandom);
            pd = 2'($urandom_range(0, 3));
            request(d, pd, ok);
            popFrame(f, ok2);
            checks++; if (!(ok && ok2)) begin errors++; $display("FAIL rand%0d_timeout got=%b%b want=11", i, ok, ok2); end
            checks++; if (f.bits !== expFrame(d, pd)) begin errors++; $display("FAIL rand%0d_bits got=%h want=%h", i, f.bits, expFrame(d, pd)); end
            checks++; if (f.len != 16 || f.ack !== 1'b0) begin errors++; $display("FAIL rand%0d_len_ack got=%0d/%b want=16/0", i, f.len, f.ack); end
            checks++; if (f.gap < TICKS) begin errors++; $display("FAIL rand%0d_gap got=%0d want>=%0d", i, f.gap, TICKS); end
            $display("rand frame %0d d=%h pd=%0d bits=%h gap=%0d", i, d, pd, f.bits, f.gap);
        end
    endtask

    task automatic test_back_to_back;
        bit ok, a, b;
        frame_t f1, f2, f3;
        int lowSeen, ackHigh;
        logic [7:0] d2;
        d2 = 8'($urandom);
        request(8'h81, 2'b01, ok);
        // Re-request on the very cycle the ack is seen cleared.
        datain   = d2;
        pdMode   = 2'b10;
        writeReq = 1'b0;
        waitAck(1'b0, 100, a);
        writeReq = 1'b1;
        waitAck(1'b1, 10, b);
        checks++; if (!(ok && a && b)) begin errors++; $display("FAIL b2b_timeout got=%b%b%b want=111", ok, a, b); end
        popFrame(f1, a);
        popFrame(f2, b);
        checks++; if (!(a && b)) begin errors++; $display("FAIL b2b_frames got=%b%b want=11", a, b); end
        checks++; if (f1.bits !== expFrame(8'h81, 2'b01)) begin errors++; $display("FAIL b2b_first got=%h want=%h", f1.bits, expFrame(8'h81, 2'b01)); end
        checks++; if (f2.bits !== expFrame(d2, 2'b10)) begin errors++; $display("FAIL b2b_second got=%h want=%h", f2.bits, expFrame(d2, 2'b10)); end
        checks++; if (f2.gap != TICKS + 1) begin errors++; $display("FAIL b2b_gap got=%0d want=%0d", f2.gap, TICKS + 1); end
        $display("b2b frames %h %h gap=%0d", f1.bits, f2.bits, f2.gap);

        // Holding the request low after the ack must not start another frame.
        @(negedge clk);
        datain   = 8'h5E;
        pdMode   = 2'b00;
        writeReq = 1'b0;
        waitAck(1'b0, 100, a);
        lowSeen = 0;
        ackHigh = 0;
        repeat (40) begin
            @(negedge clk);
            if (sync === 1'b0) lowSeen++;
            if (writeComplete !== 1'b0) ackHigh++;
        end
        writeReq = 1'b1;
        waitAck(1'b1, 10, b);
        popFrame(f3, ok);
        checks++; if (!(a && b && ok)) begin errors++; $display("FAIL hold_timeout got=%b%b%b want=111", a, b, ok); end
        checks++; if (lowSeen != 0) begin errors++; $display("FAIL hold_extra_frame got=%0d want=0", lowSeen); end
        checks++; if (ackHigh != 0) begin errors++; $display("FAIL hold_ack_dropped got=%0d want=0", ackHigh); end
        checks++; if (f3.bits !== expFrame(8'h5E, 2'b00)) begin errors++; $display("FAIL hold_bits got=%h want=%h", f3.bits, expFrame(8'h5E, 2'b00)); end
        repeat (8) @(negedge clk);
        checks++; if (fq.size() != 0) begin errors++; $display("FAIL hold_queue got=%0d want=0", fq.size()); end
        $display("hold frame bits=%h", f3.bits);
    endtask

    task automatic test_latch;
        bit ok, a, b;
        frame_t f;
        @(negedge clk);
        datain   = 8'h3C;
        pdMode   = 2'b01;
        writeReq = 1'b0;
        waitSyncLow(40, ok);
        repeat (5) @(negedge clk);
        datain = 8'hC3;
        pdMode = 2'b10;
        waitAck(1'b0, 40, a);
        writeReq = 1'b1;
        waitAck(1'b1, 10, b);
        popFrame(f, ok);
        checks++; if (!(ok && a && b)) begin errors++; $display("FAIL latch_timeout got=%b%b%b want=111", ok, a, b); end
        checks++; if (f.bits !== expFrame(8'h3C, 2'b01)) begin errors++; $display("FAIL latch_bits got=%h want=%h", f.bits, expFrame(8'h3C, 2'b01)); end
        request(8'hC3, 2'b10, a);
        popFrame(f, b);
        checks++; if (!(a && b)) begin errors++; $display("FAIL latch2_timeout got=%b%b want=11", a, b); end
        checks++; if (f.bits !== expFrame(8'hC3, 2'b10)) begin errors++; $display("FAIL latch2_bits got=%h want=%h", f.bits, expFrame(8'hC3, 2'b10)); end
        $display("latch frames done last=%h", f.bits);
    endtask

    task automatic test_withdraw;
        bit ok, ok2;
        frame_t f;
        int ackLow = 0;
        @(negedge clk);
        datain   = 8'h5A;
        pdMode   = 2'b01;
        writeReq = 1'b0;
        waitSyncLow(40, ok);
        repeat (7) @(negedge clk);
        writeReq = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (writeComplete !== 1'b1) ackLow++;
        end
        popFrame(f, ok2);
        checks++; if (!(ok && ok2)) begin errors++; $display("FAIL withdraw_timeout got=%b%b want=11", ok, ok2); end
        checks++; if (f.len != 16) begin errors++; $display("FAIL withdraw_len got=%0d want=16", f.len); end
        checks++; if (f.bits !== expFrame(8'h5A, 2'b01)) begin errors++; $display("FAIL withdraw_bits got=%h want=%h", f.bits, expFrame(8'h5A, 2'b01)); end
        checks++; if (ackLow != 0 || f.ack !== 1'b1) begin errors++; $display("FAIL withdraw_ack got=%0d/%b want=0/1", ackLow, f.ack); end
        $display("withdrawn frame bits=%h len=%0d", f.bits, f.len);
    endtask

    task automatic test_reset_mid;
        bit ok, a, b;
        frame_t fp, ff;
        int highCnt = 0;
        @(negedge clk);
        datain   = 8'h77;
        pdMode   = 2'b10;
        writeReq = 1'b0;
        waitSyncLow(40, ok);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (sync !== 1'b1 || mosi !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got=%b%b want=10", sync, mosi); end
        checks++; if (writeComplete !== 1'b1) begin errors++; $display("FAIL rstmid_ack got=%b want=1", writeComplete); end
        @(negedge clk);
        #1 reset = 1'b1;
        while (highCnt < 20) begin
            @(negedge clk);
            if (sync === 1'b1) highCnt++;
            else break;
        end
        checks++; if (highCnt != TICKS) begin errors++; $display("FAIL rstmid_quiet got=%0d want=%0d", highCnt, TICKS); end
        waitAck(1'b0, 40, a);
        writeReq = 1'b1;
        waitAck(1'b1, 10, b);
        popFrame(fp, ok);
        checks++; if (!(ok && a && b)) begin errors++; $display("FAIL rstmid_timeout got=%b%b%b want=111", ok, a, b); end
        checks++; if (fp.len != 10 || fp.ack !== 1'b1) begin errors++; $display("FAIL rstmid_partial got=%0d/%b want=10/1", fp.len, fp.ack); end
        checks++; if (fp.bits !== (expFrame(8'h77, 2'b10) >> 6)) begin errors++; $display("FAIL rstmid_partial_bits got=%h want=%h", fp.bits, expFrame(8'h77, 2'b10) >> 6); end
        popFrame(ff, ok);
        checks++; if (!ok || ff.bits !== expFrame(8'h77, 2'b10) || ff.len != 16) begin errors++; $display("FAIL rstmid_full got=%h/%0d want=%h/16", ff.bits, ff.len, expFrame(8'h77, 2'b10)); end
        $display("reset-mid partial len=%0d full=%h", fp.len, ff.bits);
    endtask

    task automatic test_idle_mosi;
        checks++; if (idleMosiBad != 0) begin errors++; $display("FAIL idle_mosi got=%0d want=0", idleMosiBad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pd();
        test_random();
        test_back_to_back();
        test_latch();
        test_withdraw();
        test_reset_mid();
        test_idle_mosi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
